// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: shared event-word layout and counter widths for the arbiter hierarchy
package lib_arbiter_pkg;
  localparam int TS_W_D = 16;
  localparam int GRP_W_D = 2;
  localparam int ROW_W_D = 2;
  localparam int COL_W_D = 2;
  localparam int Y_LSB = 0;
  localparam int X_LSB = Y_LSB + COL_W_D;
  localparam int GRP_Y_LSB = X_LSB + ROW_W_D;
  localparam int GRP_X_LSB = GRP_Y_LSB + GRP_W_D;
  localparam int TS_LSB = GRP_X_LSB + GRP_W_D;
  localparam int OVF_W = 8;
  typedef struct packed {
    logic [TS_W_D-1:0] ts;
    logic [GRP_W_D-1:0] grp_x;
    logic [GRP_W_D-1:0] grp_y;
    logic [ROW_W_D-1:0] x_add;
    logic [COL_W_D-1:0] y_add;
  } evt_t;
endpackage

// File: rtl/evt_fifo_fwft.sv
// evt_fifo_fwft: first-word-fall-through FIFO with wrap-bit pointers and registered count
module evt_fifo_fwft #(
  parameter int W = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Gate the head so the output reads zero whenever nothing is buffered
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/pixel_event_encoder.sv
// pixel_event_encoder: timestamps arbiter grants into address-event words and buffers them
module pixel_event_encoder
  import lib_arbiter_pkg::*;
#(
  parameter int Lvl_ROW_ADD = 2,
  parameter int Lvl_COL_ADD = 2,
  parameter int GRP_ADD_W = 2,
  parameter int TS_W = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int EVT_W = TS_W + 2*GRP_ADD_W + Lvl_ROW_ADD + Lvl_COL_ADD
) (
  input  logic                   grp_release_clk,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   active_i,
  input  logic [Lvl_ROW_ADD-1:0] x_add_i,
  input  logic [Lvl_COL_ADD-1:0] y_add_i,
  input  logic [GRP_ADD_W-1:0]   grp_x_i,
  input  logic [GRP_ADD_W-1:0]   grp_y_i,
  input  logic                   evt_ready_i,
  output logic                   evt_valid_o,
  output logic [EVT_W-1:0]       evt_data_o,
  output logic                   stall_o,
  output logic                   ts_wrap_o,
  output logic [OVF_W-1:0]       ovf_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [TS_W-1:0] ts;
  logic cap, push, pop, drop, empty, full;
  logic [AW:0] count, cnt_nxt;
  assign cap = enable_i & active_i;
  assign pop = !empty & evt_ready_i;
  // A full FIFO still accepts a grant when the head leaves on the same edge
  assign push = cap & (!full | pop);
  assign drop = cap & full & !pop;
  assign evt_valid_o = !empty;
  assign cnt_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  evt_fifo_fwft #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(grp_release_clk),
    .rst(reset_i),
    .push(push),
    .pop(pop),
    .din({ts, grp_x_i, grp_y_i, x_add_i, y_add_i}),
    .dout(evt_data_o),
    .empty(empty),
    .full(full),
    .count(count)
  );
  always_ff @(posedge grp_release_clk or posedge reset_i)
    if (reset_i) begin
      ts <= '0;
      ts_wrap_o <= 1'b0;
      stall_o <= 1'b0;
      ovf_cnt_o <= '0;
    end else begin
      if (enable_i) ts <= ts + 1'b1;
      ts_wrap_o <= enable_i & (&ts);
      stall_o <= cnt_nxt >= (AW+1)'(FIFO_DEPTH-2);
      if (drop && !(&ovf_cnt_o)) ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_pixel_event_encoder.sv
// tb_pixel_event_encoder: directed checks of capture, backpressure, drop, wrap, drain and reset
module tb_pixel_event_encoder;
  import lib_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst, en, act, rdy;
  logic [1:0] x, y, gx, gy;
  logic valid, stall, wrap;
  logic [23:0] data;
  logic [7:0] ovf;
  int n_assert = 0;
  int n_fail = 0;
  logic [23:0] q[$];
  logic [15:0] ts_m;
  logic [7:0] ovf_m;
  logic wrap_m;

  pixel_event_encoder dut (
    .grp_release_clk(clk),
    .reset_i(rst),
    .enable_i(en),
    .active_i(act),
    .x_add_i(x),
    .y_add_i(y),
    .grp_x_i(gx),
    .grp_y_i(gy),
    .evt_ready_i(rdy),
    .evt_valid_o(valid),
    .evt_data_o(data),
    .stall_o(stall),
    .ts_wrap_o(wrap),
    .ovf_cnt_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p, po, w;
    evt_t e;
    po = (q.size() != 0) && rdy;
    p = en && act && ((q.size() < 8) || po);
    w = en && (ts_m == 16'hFFFF);
    if (en && act && q.size() == 8 && !po && ovf_m != 8'hFF) ovf_m++;
    e = '{ts_m, gx, gy, x, y};
    @(posedge clk);
    #1;
    if (po) void'(q.pop_front());
    if (p) q.push_back(e);
    if (en) ts_m++;
    wrap_m = w;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, valid, q.size() != 0);
    chk({tag, "_data"}, data, (q.size() != 0) ? q[0] : 24'h0);
    chk({tag, "_stall"}, stall, q.size() >= 6);
    chk({tag, "_wrap"}, wrap, wrap_m);
    chk({tag, "_ovf"}, ovf, ovf_m);
  endtask

  initial begin
    rst = 1'b1; en = 0; act = 0; rdy = 0; x = 0; y = 0; gx = 0; gy = 0;
    ts_m = 0; ovf_m = 0; wrap_m = 0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;
    // single event at ts=5
    en = 1; rdy = 1;
    repeat (5) step();
    act = 1; x = 2; y = 1; gx = 1; gy = 3;
    step();
    act = 0;
    chk("t1_valid", valid, 1);
    chk("t1_data", data, 24'h000579);
    step();
    chk("t1_popped", valid, 0);
    // backpressure and overflow
    rdy = 0; act = 1;
    for (int i = 0; i < 10; i++) begin
      x = 2'(i); y = 2'(3 - i);
      step();
      if (i == 4) chk("t2_stall5", stall, 0);
      if (i == 5) chk("t2_stall6", stall, 1);
    end
    chk("t2_ovf", ovf, 2);
    chk("t2_head", data, {16'd7, 2'd1, 2'd3, 2'd0, 2'd3});
    act = 0; rdy = 1;
    for (int i = 0; i < 8; i++) begin
      chk_model("t2_drain");
      step();
    end
    chk("t2_empty", valid, 0);
    chk("t2_stall_low", stall, 0);
    // full with simultaneous push and pop
    rdy = 0; act = 1; x = 1; y = 2;
    repeat (8) step();
    chk_model("t3_full");
    rdy = 1; x = 3; y = 3;
    step();
    chk("t3_ovf", ovf, 2);
    chk("t3_stall", stall, 1);
    chk_model("t3_swap");
    act = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t3_tail", data[3:0], 4'hF);
      chk_model("t3_drain");
      step();
    end
    // timestamp wrap
    while (ts_m != 16'hFFFF) step();
    chk("t4_nowrap", wrap, 0);
    act = 1; x = 2; y = 2;
    step();
    chk("t4_wrap", wrap, 1);
    chk("t4_ts_ffff", data[23:8], 16'hFFFF);
    step();
    chk("t4_wrap_pulse", wrap, 0);
    chk("t4_ts_zero", data[23:8], 16'h0000);
    act = 0;
    step();
    chk_model("t4_end");
    // disabled drain
    rdy = 0; act = 1;
    repeat (3) step();
    en = 0; rdy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_model("t5_drain");
    end
    chk("t5_empty", valid, 0);
    en = 1; act = 1; rdy = 0;
    step();
    chk_model("t5_held_ts");
    step();
    // async reset mid-drain
    repeat (2) step();
    rdy = 1; act = 0;
    step();
    chk("t6_pre_valid", valid, 1);
    chk("t6_pre_ovf", ovf, ovf_m);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_stall", stall, 0);
    chk("t6_data", data, 0);
    q.delete(); ts_m = 0; ovf_m = 0; wrap_m = 0;
    @(negedge clk) rst = 1'b0;
    rdy = 0; act = 1; x = 1; y = 1; gx = 2; gy = 0;
    step();
    chk("t6_first", data, {16'd0, 2'd2, 2'd0, 2'd1, 2'd1});
    chk_model("t6_after");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
